gray_converter: RTL and testbench

GRAY_CONVERTER -- requirements
Module: gray_converter

---
 rtl/gray_converter_pkg.sv | 19 +
 rtl/gray_converter_if.sv | 32 +++
 rtl/luma_pipe.sv | 60 ++++++
 rtl/gray_converter.sv | 112 +++++++++++
 tb/tb_gray_converter.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gray_converter_pkg.sv
// Shared constants and state encoding for the RGB-to-gray frame converter.
// Luma weights sum to 256, so the weighted sum >> 8 always lands in 0..255.
package gray_converter_pkg;

  localparam int unsigned NUM_PIXELS_DEF = 76800;
  localparam int unsigned ADDR_W_DEF     = 17;

  localparam logic [7:0] COEF_R = 8'd77;
  localparam logic [7:0] COEF_G = 8'd150;
  localparam logic [7:0] COEF_B = 8'd29;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFlush,
    StDone
  } state_e;

endpackage

// File: rtl/gray_converter_if.sv
// Control and BRAM port bundle of gray_converter. master is the converter side,
// slave the controller/BRAM side.
interface gray_converter_if #(
  parameter int unsigned ADDR_W = 17
) ();

  logic              active;
  logic              done;
  logic [7:0]        red_data_in;
  logic [7:0]        green_data_in;
  logic [7:0]        blue_data_in;
  logic [7:0]        red_data_out;
  logic [7:0]        green_data_out;
  logic [7:0]        blue_data_out;
  logic              we;
  logic [ADDR_W-1:0] addr_read;
  logic [ADDR_W-1:0] addr_write;
  logic [7:0]        gray_max;

  modport master (
    input  active, red_data_in, green_data_in, blue_data_in,
    output done, red_data_out, green_data_out, blue_data_out,
    output we, addr_read, addr_write, gray_max
  );

  modport slave (
    output active, red_data_in, green_data_in, blue_data_in,
    input  done, red_data_out, green_data_out, blue_data_out,
    input  we, addr_read, addr_write, gray_max
  );

endinterface

// File: rtl/luma_pipe.sv
// Two-stage luma datapath: registered products, then registered gray value.
// Each stage carries a valid bit and the pixel address it belongs to.
module luma_pipe
  import gray_converter_pkg::*;
#(
  parameter int unsigned ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [7:0]        r,
  input  logic [7:0]        g,
  input  logic [7:0]        b,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic [7:0]        out_gray
);

  logic              s1_valid_q;
  logic [ADDR_W-1:0] s1_addr_q;
  logic [15:0]       prod_r_q, prod_g_q, prod_b_q;
  logic [15:0]       sum;

  // Max sum is 256 * 255 = 65280, so 16 bits never wrap.
  assign sum = prod_r_q + prod_g_q + prod_b_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      prod_r_q   <= '0;
      prod_g_q   <= '0;
      prod_b_q   <= '0;
      out_valid  <= 1'b0;
      out_addr   <= '0;
      out_gray   <= '0;
    end else if (clear) begin
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      out_valid  <= 1'b0;
      out_addr   <= '0;
    end else begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_addr_q <= in_addr;
        prod_r_q  <= {8'd0, r} * {8'd0, COEF_R};
        prod_g_q  <= {8'd0, g} * {8'd0, COEF_G};
        prod_b_q  <= {8'd0, b} * {8'd0, COEF_B};
      end
      out_valid <= s1_valid_q;
      if (s1_valid_q) begin
        out_addr <= s1_addr_q;
        out_gray <= 8'(sum >> 8);
      end
    end
  end

endmodule

// File: rtl/gray_converter.sv
// In-place RGB-to-gray frame converter: streams addresses through BRAM, writes
// the gray value back to all three channels and tracks the frame maximum.
module gray_converter
  import gray_converter_pkg::*;
#(
  parameter int unsigned NUM_PIXELS = NUM_PIXELS_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF
) (
  input logic             clk,
  input logic             rst,
  gray_converter_if.master bus
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_PIXELS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_read_q, addr_read_d;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              rd_valid_q, rd_valid_d;
  logic              done_q, done_d;
  logic [7:0]        gray_max_q, gray_max_d;
  logic              clear;
  logic              pipe_valid;
  logic [ADDR_W-1:0] pipe_addr;
  logic [7:0]        pipe_gray;

  always_comb begin
    state_d     = state_q;
    addr_read_d = addr_read_q;
    rd_valid_d  = 1'b0;
    gray_max_d  = gray_max_q;
    clear       = 1'b0;
    if (pipe_valid && (pipe_gray > gray_max_q)) gray_max_d = pipe_gray;
    unique case (state_q)
      StIdle: begin
        // Starting a frame also zeroes addr_write so it never leads addr_read.
        if (bus.active) begin
          state_d     = StRun;
          addr_read_d = '0;
          gray_max_d  = '0;
          clear       = 1'b1;
        end
      end
      StRun: begin
        if (!bus.active) begin
          state_d = StIdle;
          clear   = 1'b1;
        end else begin
          rd_valid_d = 1'b1;
          if (addr_read_q == LastAddr) state_d = StFlush;
          else addr_read_d = addr_read_q + 1'b1;
        end
      end
      StFlush: begin
        if (!bus.active) begin
          state_d = StIdle;
          clear   = 1'b1;
        end else if (pipe_valid && (pipe_addr == LastAddr)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (!bus.active) state_d = StIdle;
      end
    endcase
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_read_q <= '0;
      rd_addr_q   <= '0;
      rd_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      gray_max_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_read_q <= addr_read_d;
      rd_addr_q   <= addr_read_q;
      rd_valid_q  <= rd_valid_d;
      done_q      <= done_d;
      gray_max_q  <= gray_max_d;
    end
  end

  luma_pipe #(
    .ADDR_W (ADDR_W)
  ) u_luma_pipe (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (rd_valid_q),
    .in_addr   (rd_addr_q),
    .r         (bus.red_data_in),
    .g         (bus.green_data_in),
    .b         (bus.blue_data_in),
    .out_valid (pipe_valid),
    .out_addr  (pipe_addr),
    .out_gray  (pipe_gray)
  );

  assign bus.done           = done_q;
  assign bus.we             = pipe_valid;
  assign bus.addr_read      = addr_read_q;
  assign bus.addr_write     = pipe_addr;
  assign bus.red_data_out   = pipe_gray;
  assign bus.green_data_out = pipe_gray;
  assign bus.blue_data_out  = pipe_gray;
  assign bus.gray_max       = gray_max_q;

endmodule

// File: tb/tb_gray_converter.sv
// Directed bench for gray_converter: a 4-pixel instance for function/timing and
// a full-size 320x240 instance for the write count.
module tb_gray_converter;
  import gray_converter_pkg::*;

  localparam int unsigned SmallN = 4;
  localparam int unsigned FullN  = 76800;
  localparam int unsigned Aw     = 17;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gray_converter_if #(.ADDR_W(Aw)) s_if ();
  gray_converter_if #(.ADDR_W(Aw)) f_if ();

  gray_converter #(.NUM_PIXELS(SmallN), .ADDR_W(Aw)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (s_if.master)
  );

  gray_converter #(.NUM_PIXELS(FullN), .ADDR_W(Aw)) dut_f (
    .clk (clk),
    .rst (rst),
    .bus (f_if.master)
  );

  // Source frame and hand-computed gray results: (77R+150G+29B)>>8.
  logic [7:0] mem_r [SmallN] = '{8'd0, 8'd255, 8'd255, 8'd10};
  logic [7:0] mem_g [SmallN] = '{8'd0, 8'd255, 8'd0,   8'd20};
  logic [7:0] mem_b [SmallN] = '{8'd0, 8'd255, 8'd0,   8'd30};
  int         exp_gray [SmallN] = '{0, 255, 76, 18};

  always @(posedge clk) begin
    s_if.red_data_in   <= mem_r[s_if.addr_read[1:0]];
    s_if.green_data_in <= mem_g[s_if.addr_read[1:0]];
    s_if.blue_data_in  <= mem_b[s_if.addr_read[1:0]];
  end

  // Constant full-frame pixel (200,100,50): (15400+15000+1450)>>8 = 124.
  assign f_if.red_data_in   = 8'd200;
  assign f_if.green_data_in = 8'd100;
  assign f_if.blue_data_in  = 8'd50;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   wr_n = 0;
  int   wr_addr [64];
  int   wr_data [64];
  int   wr_cyc  [64];
  int   wr_rgb_err = 0;
  int   done_cyc = -1;
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    if (s_if.we === 1'b1) begin
      if (wr_n < 64) begin
        wr_addr[wr_n] = int'(s_if.addr_write);
        wr_data[wr_n] = int'(s_if.red_data_out);
        wr_cyc[wr_n]  = cyc;
      end
      if (s_if.red_data_out !== s_if.green_data_out || s_if.green_data_out !== s_if.blue_data_out)
        wr_rgb_err++;
      wr_n++;
    end
    if (s_if.done === 1'b1 && done_prev !== 1'b1) done_cyc = cyc;
    done_prev = s_if.done;
  end

  int          f_wr_n = 0;
  int          f_order_err = 0;
  logic [16:0] f_last = '0;
  always @(negedge clk) begin
    if (f_if.we === 1'b1) begin
      if (int'(f_if.addr_write) != f_wr_n) f_order_err++;
      f_last = f_if.addr_write;
      f_wr_n++;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done_small(input int budget);
    for (int i = 0; i < budget && s_if.done !== 1'b1; i++) tick();
    checks++;
    if (s_if.done !== 1'b1) begin
      failures++;
      $display("FAIL done_timeout: done=%0b required 1", s_if.done);
    end
  endtask

  task automatic test_reset();
    s_if.active = 1'b0;
    f_if.active = 1'b0;
    rst = 1'b1;
    tick();
    checks++;
    if ({s_if.done, s_if.we, s_if.addr_read, s_if.addr_write, s_if.red_data_out,
         s_if.green_data_out, s_if.blue_data_out, s_if.gray_max} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: done=%0b we=%0b ar=%0d aw=%0d gmax=%0d required all 0",
               s_if.done, s_if.we, s_if.addr_read, s_if.addr_write, s_if.gray_max);
    end
    checks++;
    if (dut_s.state_q !== StIdle) begin
      failures++;
      $display("FAIL reset_state: state=%0d required %0d", dut_s.state_q, StIdle);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_frame();
    int base, c0;
    base = wr_n;
    s_if.active = 1'b1;
    tick();
    c0 = cyc;
    checks++;
    if (s_if.addr_read !== 17'd0 || s_if.gray_max !== 8'd0) begin
      failures++;
      $display("FAIL frame_start: addr_read=%0d gray_max=%0d required 0 0",
               s_if.addr_read, s_if.gray_max);
    end
    wait_done_small(30);
    checks++;
    if (wr_n - base != 4) begin
      failures++;
      $display("FAIL frame_write_count: got %0d required 4", wr_n - base);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wr_addr[base+i] != i || wr_data[base+i] != exp_gray[i]) begin
        failures++;
        $display("FAIL frame_write%0d: addr=%0d data=%0d required addr=%0d data=%0d",
                 i, wr_addr[base+i], wr_data[base+i], i, exp_gray[i]);
      end
    end
    checks++;
    if (wr_rgb_err != 0) begin
      failures++;
      $display("FAIL frame_rgb_equal: mismatched writes=%0d required 0", wr_rgb_err);
    end
    checks++;
    if (s_if.gray_max !== 8'd255) begin
      failures++;
      $display("FAIL frame_gray_max: got %0d required 255", s_if.gray_max);
    end
    checks++;
    if (wr_cyc[base] != c0 + 3) begin
      failures++;
      $display("FAIL first_we_latency: got cycle %0d required %0d", wr_cyc[base], c0 + 3);
    end
    checks++;
    if (done_cyc != wr_cyc[base+3] + 1) begin
      failures++;
      $display("FAIL done_latency: got cycle %0d required %0d", done_cyc, wr_cyc[base+3] + 1);
    end
  endtask

  task automatic test_hold_done();
    int base;
    base = wr_n;
    repeat (10) tick();
    checks++;
    if (s_if.done !== 1'b1 || wr_n != base || dut_s.state_q !== StDone) begin
      failures++;
      $display("FAIL hold_done: done=%0b new_writes=%0d state=%0d required 1 0 %0d",
               s_if.done, wr_n - base, dut_s.state_q, StDone);
    end
    s_if.active = 1'b0;
    tick();
    checks++;
    if (s_if.done !== 1'b0 || dut_s.state_q !== StIdle) begin
      failures++;
      $display("FAIL done_release: done=%0b state=%0d required 0 %0d",
               s_if.done, dut_s.state_q, StIdle);
    end
    s_if.active = 1'b1;
    tick();
    checks++;
    if (s_if.addr_read !== 17'd0 || s_if.gray_max !== 8'd0 || dut_s.state_q !== StRun) begin
      failures++;
      $display("FAIL restart: addr_read=%0d gray_max=%0d state=%0d required 0 0 %0d",
               s_if.addr_read, s_if.gray_max, dut_s.state_q, StRun);
    end
    wait_done_small(30);
    checks++;
    if (wr_n - base != 4 || s_if.gray_max !== 8'd255) begin
      failures++;
      $display("FAIL restart_frame: writes=%0d gray_max=%0d required 4 255",
               wr_n - base, s_if.gray_max);
    end
    s_if.active = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_abort();
    int base;
    base = wr_n;
    s_if.active = 1'b1;
    repeat (2) tick();
    s_if.active = 1'b0;
    repeat (6) tick();
    checks++;
    if (wr_n != base || s_if.we !== 1'b0) begin
      failures++;
      $display("FAIL abort_writes: got %0d writes we=%0b required 0 0", wr_n - base, s_if.we);
    end
    checks++;
    if (dut_s.state_q !== StIdle || s_if.done !== 1'b0 || s_if.gray_max !== 8'd0) begin
      failures++;
      $display("FAIL abort_state: state=%0d done=%0b gray_max=%0d required %0d 0 0",
               dut_s.state_q, s_if.done, s_if.gray_max, StIdle);
    end
  endtask

  task automatic test_reset_mid_run();
    int base;
    base = wr_n;
    s_if.active = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({s_if.done, s_if.we, s_if.addr_read, s_if.addr_write, s_if.red_data_out,
         s_if.gray_max} !== '0) begin
      failures++;
      $display("FAIL midrun_reset_outputs: we=%0b ar=%0d aw=%0d gmax=%0d required all 0",
               s_if.we, s_if.addr_read, s_if.addr_write, s_if.gray_max);
    end
    s_if.active = 1'b0;
    tick();
    rst = 1'b0;
    repeat (5) tick();
    checks++;
    if (wr_n != base || dut_s.state_q !== StIdle) begin
      failures++;
      $display("FAIL midrun_no_writes: writes=%0d state=%0d required 0 %0d",
               wr_n - base, dut_s.state_q, StIdle);
    end
    s_if.active = 1'b1;
    tick();
    checks++;
    if (s_if.addr_read !== 17'd0 || dut_s.state_q !== StRun) begin
      failures++;
      $display("FAIL midrun_rerun: addr_read=%0d state=%0d required 0 %0d",
               s_if.addr_read, dut_s.state_q, StRun);
    end
    wait_done_small(30);
    checks++;
    if (wr_n - base != 4 || wr_addr[base] != 0 || wr_data[base+3] != 18) begin
      failures++;
      $display("FAIL midrun_rerun_frame: writes=%0d first_addr=%0d last_data=%0d required 4 0 18",
               wr_n - base, wr_addr[base], wr_data[base+3]);
    end
    s_if.active = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_full_frame();
    f_if.active = 1'b1;
    for (int i = 0; i < 80000 && f_if.done !== 1'b1; i++) tick();
    checks++;
    if (f_if.done !== 1'b1) begin
      failures++;
      $display("FAIL full_done_timeout: done=%0b required 1", f_if.done);
    end
    checks++;
    if (f_wr_n != 76800 || f_order_err != 0) begin
      failures++;
      $display("FAIL full_write_count: writes=%0d order_errors=%0d required 76800 0",
               f_wr_n, f_order_err);
    end
    checks++;
    if (f_last !== 17'd76799 || f_if.addr_write !== 17'd76799) begin
      failures++;
      $display("FAIL full_last_addr: logged=%0d addr_write=%0d required 76799",
               f_last, f_if.addr_write);
    end
    checks++;
    if (f_if.gray_max !== 8'd124) begin
      failures++;
      $display("FAIL full_gray_max: got %0d required 124", f_if.gray_max);
    end
    f_if.active = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_frame();
    test_hold_done();
    test_abort();
    test_reset_mid_run();
    test_full_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
